ntt_stage_sequencer: RTL and testbench

Control block directly upstream of the per-core butterfly array and the `router` stage. It walks a 4096-point NTT through all 12 butterfly stages. For every stage it issues a run of memory read addresses `address_0`/`address_1` together with the stage exponents `log_m`/`log_t`, which travel down the pipeline to the router. Between stages it inserts a drain gap so that the router's write-back of stage s lands before stage s+1 reads it. It also ping-pongs the buffer half used for each stage.

---
 rtl/ntt_stage_sequencer.sv | 113 +++++++++++
 tb/tb_ntt_stage_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_stage_sequencer.sv
// Stage sequencer for a 4096-point NTT: walks all butterfly stages, issuing
// paired even/odd read addresses and stage exponents, with a drain gap per stage.
module ntt_stage_sequencer #(
  parameter int LOG_CORE_COUNT = 5,
  parameter int LOG_N          = 12,
  parameter int PIPE_LAT       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stall,
  output logic       busy,
  output logic       done,
  output logic       valid,
  output logic [3:0] log_m,
  output logic [3:0] log_t,
  output logic [8:0] address_0,
  output logic [8:0] address_1,
  output logic       stage_last
);

  localparam int IW = LOG_N - LOG_CORE_COUNT - 2;
  localparam logic [IW-1:0] I_LAST = '1;
  localparam logic [3:0] M_LAST = 4'(LOG_N - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          pp;
  logic [7:0]    drain_cnt;

  // Even-word address: buffer half in bit 8, issue index on the word-pair bits.
  function automatic logic [8:0] issue_addr(input logic half, input logic [IW-1:0] i);
    logic [8:0] a;
    a        = '0;
    a[8]     = half;
    a[IW:1]  = i;
    return a;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      valid      <= 1'b0;
      stage_last <= 1'b0;
      log_m      <= '0;
      log_t      <= '0;
      address_0  <= '0;
      address_1  <= '0;
      idx        <= '0;
      pp         <= 1'b0;
      drain_cnt  <= '0;
    end else begin
      done       <= 1'b0;
      valid      <= 1'b0;
      stage_last <= 1'b0;
      case (state)
        ST_IDLE: begin
          // done is still high in the first IDLE cycle; a start there is dropped.
          if (start && !done) begin
            busy      <= 1'b1;
            log_m     <= '0;
            log_t     <= M_LAST;
            pp        <= 1'b0;
            valid     <= 1'b1;
            address_0 <= issue_addr(1'b0, '0);
            address_1 <= issue_addr(1'b0, '0) | 9'd1;
            idx       <= IW'(1);
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            valid     <= 1'b1;
            address_0 <= issue_addr(pp, idx);
            address_1 <= issue_addr(pp, idx) | 9'd1;
            idx       <= idx + 1'b1;
            if (idx == I_LAST) begin
              stage_last <= 1'b1;
              drain_cnt  <= 8'(PIPE_LAT - 1);
              state      <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            if (log_m == M_LAST) begin
              state <= ST_DONE;
            end else begin
              log_m <= log_m + 4'd1;
              log_t <= log_t - 4'd1;
              pp    <= ~pp;
              idx   <= '0;
              state <= ST_RUN;
            end
          end else begin
            drain_cnt <= drain_cnt - 8'd1;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Scoreboard bench for ntt_stage_sequencer: expected issue stream is queued at
// start, a negedge monitor pops and compares each valid issue and done timing.
module tb_ntt_stage_sequencer;

  localparam int PL    = 8;
  localparam int LN    = 12;
  localparam int STEPS = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       busy, done, valid, stage_last;
  logic [3:0] log_m, log_t;
  logic [8:0] address_0, address_1;

  ntt_stage_sequencer #(.LOG_CORE_COUNT(5), .LOG_N(LN), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .busy(busy), .done(done), .valid(valid), .log_m(log_m), .log_t(log_t),
    .address_0(address_0), .address_1(address_1), .stage_last(stage_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct packed {
    logic [8:0] a0;
    logic [8:0] a1;
    logic [3:0] lm;
    logic [3:0] lt;
    logic       last;
  } item_t;

  item_t exp_q[$];
  int checks = 0, errors = 0;
  int e0 = 0, done_lat = 0, valid_cnt = 0, sl_cnt = 0, last_sl_cyc = 0, zeros = 0;
  bit done_seen = 0, gap_en = 0, armed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc - e0);
    end
  endtask

  // Reference: stage s reads half s%2, issue i reads words 2i and 2i+1.
  task automatic push_model();
    item_t it;
    for (int s = 0; s < LN; s++) begin
      for (int i = 0; i < STEPS; i++) begin
        it.a0   = 9'((s % 2) * 256 + 2 * i);
        it.a1   = 9'((s % 2) * 256 + 2 * i + 1);
        it.lm   = 4'(s);
        it.lt   = 4'(LN - 1 - s);
        it.last = (i == STEPS - 1);
        exp_q.push_back(it);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got address_0=%0d expected no issue", address_0);
        end else begin
          item_t e, g;
          e = exp_q.pop_front();
          g = '{a0: address_0, a1: address_1, lm: log_m, lt: log_t, last: stage_last};
          chk("issue", 64'(g), 64'(e));
        end
        if (gap_en && armed) chk("drain_gap", 64'(zeros), 64'(PL));
        armed = 0;
        if (stage_last) begin
          armed = 1;
          zeros = 0;
          sl_cnt++;
          last_sl_cyc = cyc;
        end
      end else if (armed) begin
        zeros++;
      end
      if (done) begin
        done_seen = 1;
        done_lat  = cyc - e0 + 1;
        armed     = 0;
        chk("done_after_last_issue", 64'(cyc - last_sl_cyc), 64'(PL + 1));
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    exp_q.delete();
    push_model();
    valid_cnt = 0;
    sl_cnt    = 0;
    done_seen = 0;
    armed     = 0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0    = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done_seen), 64'd1);
  endtask

  task automatic end_of_run(input string tag, input int lat);
    chk({tag, "_done_latency"}, 64'(done_lat), 64'(lat));
    chk({tag, "_valid_count"}, 64'(valid_cnt), 64'(LN * STEPS));
    chk({tag, "_stage_last_count"}, 64'(sl_cnt), 64'(LN));
    chk({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({busy, done, valid, stage_last, log_m, log_t, address_0, address_1}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", 64'({busy, valid, done}), 64'd0);

    // Run 1: no stall, start re-pulsed mid-run and around done
    gap_en = 1;
    do_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    while (cyc - e0 < 99) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_repulse", 64'(busy), 64'd1);
    n = 0;
    while (cyc - e0 < 479 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    chk("done_pulse_481", 64'(done), 64'd1);
    chk("busy_low_with_done", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("no_restart_busy", 64'(busy), 64'd0);
    chk("no_restart_valid", 64'(valid), 64'd0);
    chk("done_single_cycle", 64'(done), 64'd0);
    @(negedge clk);
    chk("still_idle", 64'({busy, valid}), 64'd0);
    chk("done_seen", 64'(done_seen), 64'd1);
    end_of_run("plain", 1 + LN * (STEPS + PL));

    // Run 2: 5-cycle stall just after issue 9 of stage 3
    gap_en = 0;
    do_start();
    n = 0;
    while (!(valid && address_0 == 9'd274 && log_m == 4'd3) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_stage3_i9", 64'(address_0), 64'd274);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid_low", 64'(valid), 64'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("resume_i10", 64'({valid, address_0}), 64'({1'b1, 9'd276}));
    wait_done(1000);
    end_of_run("stall5", 1 + LN * (STEPS + PL) + 5);

    // Run 3: random stalls throughout
    do_start();
    n = 0;
    while (!done_seen && n < 3000) begin
      stall = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      n++;
    end
    stall = 1'b0;
    chk("random_done_seen", 64'(done_seen), 64'd1);
    chk("random_valid_count", 64'(valid_cnt), 64'(LN * STEPS));
    chk("random_stage_last_count", 64'(sl_cnt), 64'(LN));
    chk("random_queue_drained", 64'(exp_q.size()), 64'd0);

    // Run 4: reset mid-transform, no done afterwards
    do_start();
    while (cyc - e0 < 199) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs",
           64'({busy, done, valid, stage_last, log_m, log_t, address_0, address_1}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    done_seen = 0;
    repeat (600) @(negedge clk);
    chk("no_done_after_reset", 64'(done_seen), 64'd0);
    chk("idle_after_mid_reset", 64'({busy, valid}), 64'd0);

    // Run 5: full run after reset recovery
    gap_en = 1;
    do_start();
    wait_done(1000);
    end_of_run("post_reset", 1 + LN * (STEPS + PL));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
